// File: rtl/cellram_arbiter_pkg.sv
// Shared encodings for the Cellular RAM arbiter so that every consumer of OWNER
// (bus interface, debug LEDs) decodes the grant identically.
package cellram_arbiter_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_DISP = 2'd1,
      OWN_CAM  = 2'd2,
      OWN_CPU  = 2'd3
   } owner_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RECOVER = 2'd2
   } state_t;

   // Request fields captured from the winning client at grant time
   typedef struct packed {
      logic [22:0] addr;
      logic [15:0] wdata;
      logic        we;
      logic [1:0]  be;
   } mem_req_t;

endpackage

// File: rtl/cellram_arbiter.sv
// Single owner of the Cellular RAM pins: fixed-priority arbitration between display,
// camera and CPU with CPU anti-starvation, and an IDLE/ACCESS/RECOVER strobe sequencer.
module cellram_arbiter
   import cellram_arbiter_pkg::*;
#(
   parameter int ACCESS_CYC = 4,
   parameter int CPU_MAX    = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        DREQ,
   input  logic [22:0] DADDR,
   output logic        DACK,
   output logic [15:0] DRDATA,
   input  logic        CREQ,
   input  logic [22:0] CADDR,
   input  logic [15:0] CWDATA,
   output logic        CACK,
   input  logic        PREQ,
   input  logic        PWE,
   input  logic [22:0] PADDR,
   input  logic [15:0] PWDATA,
   input  logic [1:0]  PBE,
   output logic        PACK,
   output logic [15:0] PRDATA,
   output logic [22:0] MEMADDR,
   inout  wire  [15:0] MEMDQ,
   output logic        MEMnOE,
   output logic        MEMnWE,
   output logic        MEMnUB,
   output logic        MEMnLB,
   output logic [1:0]  OWNER
);

   localparam int TW = $clog2(ACCESS_CYC);
   localparam int WW = $clog2(CPU_MAX + 1);

   state_t        state, state_nx;
   owner_t        win, owner_q;
   mem_req_t      sel;
   logic [TW-1:0] timer;
   logic [WW-1:0] cpu_wait;
   logic [15:0]   wdata_q;
   logic          we_q;
   logic          dq_oe;

   assign OWNER = owner_q;
   // Enable is registered and only set for writes, so DQ never fights the RAM under nOE
   assign MEMDQ = dq_oe ? wdata_q : 16'hzzzz;

   always_comb begin
      state_nx = state;
      win      = OWN_NONE;
      sel      = '{addr: DADDR, wdata: 16'h0000, we: 1'b0, be: 2'b11};
      unique case (state)
         ST_IDLE: begin
            // A starved CPU overrides the fixed display > camera > CPU order
            if (PREQ && cpu_wait == WW'(CPU_MAX)) win = OWN_CPU;
            else if (DREQ)                       win = OWN_DISP;
            else if (CREQ)                       win = OWN_CAM;
            else if (PREQ)                       win = OWN_CPU;
            if (win != OWN_NONE) state_nx = ST_ACCESS;
         end
         ST_ACCESS:  if (timer == '0) state_nx = ST_RECOVER;
         ST_RECOVER: state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
      case (win)
         OWN_CAM: sel = '{addr: CADDR, wdata: CWDATA, we: 1'b1, be: 2'b11};
         OWN_CPU: sel = '{addr: PADDR, wdata: PWDATA, we: PWE, be: (PWE ? PBE : 2'b11)};
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         owner_q  <= OWN_NONE;
         timer    <= '0;
         cpu_wait <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         dq_oe    <= 1'b0;
         MEMADDR  <= '0;
         MEMnOE   <= 1'b1;
         MEMnWE   <= 1'b1;
         MEMnUB   <= 1'b1;
         MEMnLB   <= 1'b1;
         DACK     <= 1'b0;
         CACK     <= 1'b0;
         PACK     <= 1'b0;
         DRDATA   <= '0;
         PRDATA   <= '0;
      end else begin
         DACK <= 1'b0;
         CACK <= 1'b0;
         PACK <= 1'b0;

         if (!PREQ || win == OWN_CPU)
            cpu_wait <= '0;
         else if (win != OWN_NONE && cpu_wait != WW'(CPU_MAX))
            cpu_wait <= cpu_wait + WW'(1);

         unique case (state)
            ST_IDLE: begin
               owner_q <= win;
               if (win != OWN_NONE) begin
                  MEMADDR <= sel.addr;
                  wdata_q <= sel.wdata;
                  we_q    <= sel.we;
                  dq_oe   <= sel.we;
                  MEMnOE  <= sel.we;
                  MEMnWE  <= ~sel.we;
                  MEMnUB  <= ~sel.be[1];
                  MEMnLB  <= ~sel.be[0];
                  timer   <= TW'(ACCESS_CYC - 1);
               end
            end
            ST_ACCESS: begin
               if (timer == '0) begin
                  MEMnOE <= 1'b1;
                  MEMnWE <= 1'b1;
                  MEMnUB <= 1'b1;
                  MEMnLB <= 1'b1;
                  if (!we_q) begin
                     if (owner_q == OWN_DISP) DRDATA <= MEMDQ;
                     else                     PRDATA <= MEMDQ;
                  end
                  DACK <= (owner_q == OWN_DISP);
                  CACK <= (owner_q == OWN_CAM);
                  PACK <= (owner_q == OWN_CPU);
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            ST_RECOVER: begin
               // Write data is held through RECOVER and released on the way back to IDLE
               owner_q <= OWN_NONE;
               dq_oe   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cellram_arbiter.sv
// Bench for cellram_arbiter: async RAM model, transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_cellram_arbiter;
   import cellram_arbiter_pkg::*;

   localparam int AC = 4;
   localparam int CM = 8;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        DREQ = 1'b0;
   logic [22:0] DADDR = '0;
   logic        DACK;
   logic [15:0] DRDATA;
   logic        CREQ = 1'b0;
   logic [22:0] CADDR = '0;
   logic [15:0] CWDATA = '0;
   logic        CACK;
   logic        PREQ = 1'b0;
   logic        PWE = 1'b0;
   logic [22:0] PADDR = '0;
   logic [15:0] PWDATA = '0;
   logic [1:0]  PBE = 2'b11;
   logic        PACK;
   logic [15:0] PRDATA;
   logic [22:0] MEMADDR;
   wire  [15:0] MEMDQ;
   logic        MEMnOE, MEMnWE, MEMnUB, MEMnLB;
   logic [1:0]  OWNER;

   cellram_arbiter #(.ACCESS_CYC(AC), .CPU_MAX(CM)) dut (
      .CLK(CLK), .RST(RST),
      .DREQ(DREQ), .DADDR(DADDR), .DACK(DACK), .DRDATA(DRDATA),
      .CREQ(CREQ), .CADDR(CADDR), .CWDATA(CWDATA), .CACK(CACK),
      .PREQ(PREQ), .PWE(PWE), .PADDR(PADDR), .PWDATA(PWDATA), .PBE(PBE),
      .PACK(PACK), .PRDATA(PRDATA),
      .MEMADDR(MEMADDR), .MEMDQ(MEMDQ), .MEMnOE(MEMnOE), .MEMnWE(MEMnWE),
      .MEMnUB(MEMnUB), .MEMnLB(MEMnLB), .OWNER(OWNER)
   );

   always #10 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] pre(input int i);
      return 16'(i) ^ 16'hA5C3;
   endfunction

   // Async RAM: drives DQ while read-enabled, stores bytes while nWE is low
   logic [15:0] ram     [0:65535];
   logic [15:0] ref_mem [0:65535];
   logic [15:0] ram_q;
   assign ram_q = ram[MEMADDR[15:0]];
   assign MEMDQ = (!MEMnOE && MEMnWE) ? ram_q : 16'hzzzz;

   initial forever begin
      @(negedge CLK);
      if (!MEMnWE) begin
         if (!MEMnUB) ram[MEMADDR[15:0]][15:8] = MEMDQ[15:8];
         if (!MEMnLB) ram[MEMADDR[15:0]][7:0]  = MEMDQ[7:0];
      end
   end

   // Reference model: a granted transaction occupies cycles 1..AC (strobes) and AC+1 (ack)
   logic        synced = 1'b0;
   logic        m_busy = 1'b0;
   int          m_p = 0;
   owner_t      m_own = OWN_NONE;
   owner_t      m_win;
   logic [22:0] m_addr = '0;
   logic [15:0] m_wdata = '0;
   logic        m_we = 1'b0;
   logic [1:0]  m_be = 2'b11;
   int          m_wait = 0;
   logic [15:0] exp_dr = '0, exp_pr = '0;
   logic        acc, rec;
   logic [1:0]  e_bytes;

   initial forever begin
      @(negedge CLK);
      if (synced) begin
         acc     = m_busy && m_p <= AC;
         rec     = m_busy && m_p == AC + 1;
         e_bytes = acc ? ~m_be : 2'b11;
         check("owner", 32'(OWNER), 32'(m_busy ? m_own : OWN_NONE));
         check("strobes", 32'({MEMnOE, MEMnWE, MEMnUB, MEMnLB}),
               32'({!(acc && !m_we), !(acc && m_we), e_bytes}));
         check("acks", 32'({DACK, CACK, PACK}),
               32'(rec ? {m_own == OWN_DISP, m_own == OWN_CAM, m_own == OWN_CPU} : 3'b000));
         check("drdata", 32'(DRDATA), 32'(exp_dr));
         check("prdata", 32'(PRDATA), 32'(exp_pr));
         if (m_busy) check("memaddr", 32'(MEMADDR), 32'(m_addr));
         if (m_busy && m_we) check("dq_write", 32'(MEMDQ), 32'(m_wdata));
         else if (acc)       check("dq_read", 32'(MEMDQ), 32'(ref_mem[m_addr[15:0]]));
      end
      if (RST) begin
         synced = 1'b1;
         m_busy = 1'b0;
         m_wait = 0;
         exp_dr = '0;
         exp_pr = '0;
      end else begin
         if (m_busy) begin
            if (m_p == AC + 1) m_busy = 1'b0;
            else begin
               m_p++;
               if (m_p == AC + 1) begin
                  if (m_we) begin
                     if (m_be[1]) ref_mem[m_addr[15:0]][15:8] = m_wdata[15:8];
                     if (m_be[0]) ref_mem[m_addr[15:0]][7:0]  = m_wdata[7:0];
                  end else if (m_own == OWN_DISP) exp_dr = ref_mem[m_addr[15:0]];
                  else                            exp_pr = ref_mem[m_addr[15:0]];
               end
            end
            if (!PREQ) m_wait = 0;
         end else begin
            m_win = OWN_NONE;
            if (PREQ && m_wait == CM) m_win = OWN_CPU;
            else if (DREQ)            m_win = OWN_DISP;
            else if (CREQ)            m_win = OWN_CAM;
            else if (PREQ)            m_win = OWN_CPU;
            if (!PREQ || m_win == OWN_CPU) m_wait = 0;
            else if (m_win != OWN_NONE && m_wait < CM) m_wait++;
            if (m_win != OWN_NONE) begin
               m_busy = 1'b1;
               m_p    = 1;
               m_own  = m_win;
               case (m_win)
                  OWN_DISP: begin m_addr = DADDR; m_we = 1'b0; m_be = 2'b11; end
                  OWN_CAM:  begin m_addr = CADDR; m_we = 1'b1; m_be = 2'b11; m_wdata = CWDATA; end
                  default:  begin
                     m_addr = PADDR; m_we = PWE; m_wdata = PWDATA;
                     m_be = PWE ? PBE : 2'b11;
                  end
               endcase
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, bench did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic wait_ack(input int which, output int n);
      logic a;
      n = 0;
      do begin
         tick();
         n++;
         a = (which == 1) ? DACK : (which == 2) ? CACK : PACK;
      end while (!a && n < 60);
      check("ack_seen", 32'(a), 1);
   endtask

   function automatic logic [22:0] rnd_addr();
      return 23'($urandom_range(255));
   endfunction

   initial begin
      int          n, cnt, seq, prev, dn, mism;
      logic [15:0] pv;
      logic        allow;

      for (int i = 0; i < 65536; i++) begin
         ram[i]     = pre(i);
         ref_mem[i] = pre(i);
      end

      tick();
      tick();
      check("rst_strobes", 32'({MEMnOE, MEMnWE, MEMnUB, MEMnLB}), 'hF);
      check("rst_memaddr", 32'(MEMADDR), 0);
      check("rst_owner", 32'(OWNER), 0);
      check("rst_acks", 32'({DACK, CACK, PACK}), 0);
      check("rst_rdata", 32'({DRDATA, PRDATA}), 0);
      RST = 1'b0;
      tick();

      // 1: CPU upper-byte write
      PREQ = 1; PWE = 1; PADDR = 23'h000123; PWDATA = 16'hBEEF; PBE = 2'b10;
      n = 0; cnt = 0;
      do begin
         tick();
         n++;
         if (!MEMnWE) begin
            cnt++;
            check("t1_ublb", 32'({MEMnUB, MEMnLB}), 'b01);
            check("t1_addr", 32'(MEMADDR), 'h123);
         end
      end while (!PACK && n < 20);
      check("t1_pack_latency", n, 5);
      check("t1_nwe_cycles", cnt, 4);
      PREQ = 0; PWE = 0;
      tick();
      check("t1_pack_pulse", 32'(PACK), 0);
      pv = pre('h123);
      check("t1_ram_bytes", 32'(ram['h123]), {16'h0, 8'hBE, pv[7:0]});

      // 2: display read of preloaded word
      ram['hABCD] = 16'h1234;
      ref_mem['hABCD] = 16'h1234;
      DREQ = 1; DADDR = 23'h00ABCD;
      n = 0; cnt = 0;
      do begin
         tick();
         n++;
         if (!MEMnOE) cnt++;
      end while (!DACK && n < 20);
      check("t2_dack_latency", n, 5);
      check("t2_noe_cycles", cnt, 4);
      check("t2_drdata", 32'(DRDATA), 'h1234);
      check("t2_prdata_held", 32'(PRDATA), 0);
      DREQ = 0;
      tick();

      // 3: simultaneous requests
      DREQ = 1; DADDR = 23'h000040;
      CREQ = 1; CADDR = 23'h000041; CWDATA = 16'hC0DE;
      PREQ = 1; PWE = 0; PADDR = 23'h000041; PBE = 2'b11;
      n = 0; seq = 0; prev = 0;
      do begin
         tick();
         n++;
         if (OWNER != 0 && prev == 0) seq = seq * 4 + int'(OWNER);
         prev = int'(OWNER);
         if (DACK) DREQ = 0;
         if (CACK) CREQ = 0;
         if (PACK) PREQ = 0;
      end while ((DREQ || CREQ || PREQ) && n < 40);
      check("t3_order", seq, 27);
      check("t3_total_cycles", n + 1, 18);
      check("t3_cpu_read", 32'(PRDATA), 'hC0DE);
      tick();

      // 4: continuous display traffic starves the CPU only CPU_MAX times
      DREQ = 1; DADDR = 23'h000080;
      PREQ = 1; PWE = 0; PADDR = 23'h000081;
      for (int r = 0; r < 2; r++) begin
         dn = 0; n = 0;
         do begin
            tick();
            n++;
            if (DACK) dn++;
         end while (!PACK && n < 100);
         check("t4_disp_before_cpu", dn, 8);
      end
      PREQ = 0;
      wait_ack(1, n);
      check("t4_disp_resume", n, 6);
      DREQ = 0;
      tick();

      // 5: CPU write then read back
      PREQ = 1; PWE = 1; PADDR = 23'h000010; PWDATA = 16'h5A5A; PBE = 2'b11;
      wait_ack(3, n);
      PWE = 0;
      wait_ack(3, n);
      check("t5_readback", 32'(PRDATA), 'h5A5A);
      PREQ = 0;
      tick();

      // 6: reset in the middle of a camera write
      CREQ = 1; CADDR = 23'h000200; CWDATA = 16'h7777;
      n = 0;
      do begin tick(); n++; end while (OWNER != 2'd2 && n < 20);
      tick();
      RST = 1;
      tick();
      RST = 0;
      CREQ = 0;
      check("t6_strobes", 32'({MEMnOE, MEMnWE, MEMnUB, MEMnLB}), 'hF);
      check("t6_owner", 32'(OWNER), 0);
      check("t6_prdata_cleared", 32'(PRDATA), 0);
      cnt = (CACK) ? 1 : 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (CACK) cnt++;
      end
      check("t6_no_cack", cnt, 0);
      CREQ = 1;
      wait_ack(2, n);
      check("t6_retry_latency", n, 5);
      CREQ = 0;
      tick();
      check("t6_ram", 32'(ram['h200]), 'h7777);

      // Randomized traffic, then drain outstanding requests
      for (int c = 0; c < 3100; c++) begin
         tick();
         allow = (c < 3000);
         if (DREQ) begin
            if (DACK) begin
               if (allow && $urandom_range(1) == 1) DADDR = rnd_addr();
               else DREQ = 0;
            end
         end else if (allow && $urandom_range(3) == 0) begin
            DREQ = 1; DADDR = rnd_addr();
         end
         if (CREQ) begin
            if (CACK) begin
               if (allow && $urandom_range(1) == 1) begin
                  CADDR = rnd_addr(); CWDATA = 16'($urandom);
               end else CREQ = 0;
            end
         end else if (allow && $urandom_range(3) == 0) begin
            CREQ = 1; CADDR = rnd_addr(); CWDATA = 16'($urandom);
         end
         if (PREQ) begin
            if (PACK) begin
               if (allow && $urandom_range(1) == 1) begin
                  PWE = 1'($urandom); PADDR = rnd_addr(); PWDATA = 16'($urandom);
                  PBE = 2'($urandom_range(3));
               end else PREQ = 0;
            end
         end else if (allow && $urandom_range(2) == 0) begin
            PREQ = 1; PWE = 1'($urandom); PADDR = rnd_addr(); PWDATA = 16'($urandom);
            PBE = 2'($urandom_range(3));
         end
      end
      check("drain_done", 32'({DREQ, CREQ, PREQ}), 0);
      tick();
      tick();
      mism = 0;
      for (int i = 0; i < 256; i++)
         if (ram[i] !== ref_mem[i]) mism++;
      check("ram_contents", mism, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
